// File: rtl/uart_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_adc_pkg
// Description : Shared types, ASCII codes and digit-count helpers for the
//               ADC-to-UART reporter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_adc_pkg;

  typedef enum logic [2:0] {IDLE, CONV, LOAD, SEND, WAITB, DONE} state_t;

  // Which field of the frame the byte pointer currently sits in.
  typedef enum logic [2:0] {P_PRE, P_DIG, P_COMMA, P_CR, P_LF} part_t;

  localparam logic [7:0] C_CH_A  = 8'h41;
  localparam logic [7:0] C_CH_D  = 8'h44;
  localparam logic [7:0] C_COLON = 8'h3A;
  localparam logic [7:0] C_COMMA = 8'h2C;
  localparam logic [7:0] C_CR    = 8'h0D;
  localparam logic [7:0] C_LF    = 8'h0A;
  localparam logic [7:0] C_ZERO  = 8'h30;

  // Number of decimal digits needed for the largest w-bit unsigned value.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

  // Nibble to uppercase ASCII hex character.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (C_ZERO + {4'd0, n}) : (C_CH_A + {4'd0, n} - 8'd10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2dec_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2dec_seq
// Description : Sequential shift-add-3 (double dabble) binary to BCD
//               converter, one bit per cycle; done pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2dec_seq #(
  parameter int DATA_W = 8,
  parameter int DEC_D  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic                 done,
  output logic [4*DEC_D-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  bin_q, bin_d;
  logic [4*DEC_D-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  // Add-3 correction on every digit, then shift the whole BCD:binary pair left.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    adj    = bcd_q;
    for (int i = 0; i < DEC_D; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {adj[4*DEC_D-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q - 1'b1;
      done_d         = (cnt_q == CNT_W'(1));
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. No reset: a byte in flight always
//               completes. The shifter holds the inverted frame so that an
//               all-zero power-up state idles the line high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       send_busy,
  output logic       tx_pin
);

  localparam int BIT_CLKS = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int BAUD_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  logic [9:0]        shift_n_q, shift_n_d;
  logic [3:0]        bits_q, bits_d;
  logic [BAUD_W-1:0] baud_q, baud_d;

  // Load {stop, data, start} on send_en when idle, shift one bit per baud period.
  always_comb begin
    shift_n_d = shift_n_q;
    bits_d    = bits_q;
    baud_d    = baud_q;
    if (bits_q == 4'd0) begin
      if (send_en) begin
        shift_n_d = ~{1'b1, send_data, 1'b0};
        bits_d    = 4'd10;
        baud_d    = '0;
      end
    end else if (baud_q == BAUD_W'(BIT_CLKS - 1)) begin
      baud_d    = '0;
      shift_n_d = {1'b0, shift_n_q[9:1]};
      bits_d    = bits_q - 4'd1;
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  // Transmitter registers, deliberately without reset.
  always_ff @(posedge clk) begin
    shift_n_q <= shift_n_d;
    bits_q    <= bits_d;
    baud_q    <= baud_d;
  end

  assign send_busy = (bits_q != 4'd0);
  assign tx_pin    = ~shift_n_q[0];

endmodule
`default_nettype wire

// File: rtl/uart_adc_report.sv
`default_nettype none
// ============================================================================
// Module      : uart_adc_report
// Description : Snapshots N_CH ADC words and reports them over UART as
//               "AD:<v0>,<v1>,...\r\n" in zero-padded decimal or hex.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_adc_report #(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200,
  parameter int SEND_FRE  = 2,
  parameter int N_CH      = 4,
  parameter int DATA_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] adc_data,
  input  logic                   mode,
  input  logic                   hex_mode,
  input  logic                   trig,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   uart_tx
);

  import uart_adc_pkg::*;

  localparam int DEC_D  = dec_digits(DATA_W);
  localparam int HEX_D  = hex_digits(DATA_W);
  localparam int HEXW   = 4 * HEX_D;
  localparam int PERIOD = CLK_FRE * 1000000 / SEND_FRE;
  localparam int PER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DIG_W  = (DEC_D > 1) ? $clog2(DEC_D) : 1;

  state_t                 state_q, state_d;
  part_t                  part_q, part_d;
  logic [PER_W-1:0]       per_q, per_d;
  logic [N_CH*DATA_W-1:0] snap_q, snap_d;
  logic                   hex_q, hex_d, busy_q, busy_d, ovr_q, ovr_d;
  logic                   conv_q, conv_d, seen_q, seen_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [DIG_W-1:0]       dig_q, dig_d, last_dig;
  logic [1:0]             pre_q, pre_d;
  logic [7:0]             digit_q [DEC_D];
  logic [7:0]             digit_d [DEC_D];
  logic [7:0]             send_data_q, send_data_d;
  logic                   tick, start_ev, b2d_start, b2d_done, send_en, send_busy;
  logic [DATA_W-1:0]      ch_val;
  logic [HEXW-1:0]        hex_val;
  logic [4*DEC_D-1:0]     bcd;

  assign tick     = (per_q == PER_W'(PERIOD - 1));
  assign start_ev = mode ? trig : tick;
  assign ch_val   = snap_q[ch_q*DATA_W +: DATA_W];
  assign hex_val  = HEXW'(ch_val);
  assign last_dig = hex_q ? DIG_W'(HEX_D - 1) : DIG_W'(DEC_D - 1);

  // Free-running period counter; its wrap is the periodic start tick.
  always_comb begin
    per_d = tick ? '0 : per_q + 1'b1;
  end

  // Frame sequencer: convert a channel, then load/send/await each byte.
  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    snap_d      = snap_q;
    hex_d       = hex_q;
    busy_d      = busy_q;
    ovr_d       = ovr_q;
    conv_d      = conv_q;
    seen_d      = seen_q;
    ch_d        = ch_q;
    dig_d       = dig_q;
    pre_d       = pre_q;
    digit_d     = digit_q;
    send_data_d = send_data_q;
    send_en     = 1'b0;
    b2d_start   = 1'b0;
    frame_done  = 1'b0;
    if (start_ev && state_q != IDLE) ovr_d = 1'b1;
    case (state_q)
      IDLE: if (start_ev) begin
        snap_d  = adc_data;
        hex_d   = hex_mode;
        busy_d  = 1'b1;
        ch_d    = '0;
        pre_d   = 2'd0;
        part_d  = P_PRE;
        conv_d  = 1'b0;
        state_d = CONV;
      end
      CONV: begin
        if (hex_q) begin
          for (int i = 0; i < HEX_D; i++) digit_d[i] = hex_char(hex_val[4*(HEX_D-1-i) +: 4]);
          state_d = LOAD;
        end else if (!conv_q) begin
          b2d_start = 1'b1;
          conv_d    = 1'b1;
        end else if (b2d_done) begin
          for (int i = 0; i < DEC_D; i++) digit_d[i] = C_ZERO + {4'd0, bcd[4*(DEC_D-1-i) +: 4]};
          conv_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        case (part_q)
          P_PRE:   send_data_d = (pre_q == 2'd0) ? C_CH_A : ((pre_q == 2'd1) ? C_CH_D : C_COLON);
          P_DIG:   send_data_d = digit_q[dig_q];
          P_COMMA: send_data_d = C_COMMA;
          P_CR:    send_data_d = C_CR;
          default: send_data_d = C_LF;
        endcase
        state_d = SEND;
      end
      SEND: if (!send_busy) begin
        send_en = 1'b1;
        seen_d  = 1'b0;
        state_d = WAITB;
      end
      WAITB: begin
        if (!seen_q) begin
          if (send_busy) seen_d = 1'b1;
        end else if (!send_busy) begin
          state_d = LOAD;
          case (part_q)
            P_PRE: begin
              if (pre_q == 2'd2) begin
                part_d = P_DIG;
                dig_d  = '0;
              end else begin
                pre_d = pre_q + 2'd1;
              end
            end
            P_DIG: begin
              if (dig_q == last_dig) part_d = (ch_q == CH_W'(N_CH - 1)) ? P_CR : P_COMMA;
              else                   dig_d  = dig_q + 1'b1;
            end
            P_COMMA: begin
              ch_d    = ch_q + 1'b1;
              dig_d   = '0;
              part_d  = P_DIG;
              state_d = CONV;
            end
            P_CR:    part_d  = P_LF;
            default: state_d = DONE;
          endcase
        end
      end
      DONE: begin
        frame_done = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      part_q      <= P_PRE;
      per_q       <= '0;
      snap_q      <= '0;
      hex_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      conv_q      <= 1'b0;
      seen_q      <= 1'b0;
      ch_q        <= '0;
      dig_q       <= '0;
      pre_q       <= 2'd0;
      digit_q     <= '{default: C_ZERO};
      send_data_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      part_q      <= part_d;
      per_q       <= per_d;
      snap_q      <= snap_d;
      hex_q       <= hex_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      conv_q      <= conv_d;
      seen_q      <= seen_d;
      ch_q        <= ch_d;
      dig_q       <= dig_d;
      pre_q       <= pre_d;
      digit_q     <= digit_d;
      send_data_q <= send_data_d;
    end
  end

  assign busy    = busy_q;
  assign overrun = ovr_q;

  bin2dec_seq #(.DATA_W(DATA_W), .DEC_D(DEC_D)) u_b2d (
    .clk   (clk),
    .rst   (rst),
    .start (b2d_start),
    .bin   (ch_val),
    .done  (b2d_done),
    .bcd   (bcd)
  );

  uart_tx #(.CLK_FRE(CLK_FRE), .BAUD_RATE(UART_RATE)) u_tx (
    .clk       (clk),
    .send_en   (send_en),
    .send_data (send_data_q),
    .send_busy (send_busy),
    .tx_pin    (uart_tx)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_adc_report.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_adc_report
// Description : Self-checking bench for uart_adc_report: three instances
//               (8/12/16-bit channels), UART byte monitors, expected-frame
//               scoreboard, periodic/overrun/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_adc_report;

  localparam int BIT_CLKS = 5;  // CLK_FRE=1, UART_RATE=200000

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adc0 = '0;
  logic [23:0] adc1 = '0;
  logic [31:0] adc2 = '0;
  logic [2:0]  mode_v = 3'b111;
  logic [2:0]  hex_v = 3'b000;
  logic [2:0]  trig_v = 3'b000;
  wire  [2:0]  busy_v, fd_v, ov_v, tx_v;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fd_cnt [3];
  int se_cnt [3];
  int hs_err = 0;
  int ferr = 0;
  byte unsigned rxq [3][$];
  string sb_q [$];
  string crlf;

  typedef struct packed {
    logic [1:0]   k;
    logic [15:0]  c0;
    logic [15:0]  c1;
    logic         hx;
    logic [127:0] txt;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  uart_adc_report #(.CLK_FRE(1), .UART_RATE(200000), .SEND_FRE(1000), .N_CH(2), .DATA_W(8)) u0 (
    .clk(clk), .rst(rst), .adc_data(adc0), .mode(mode_v[0]), .hex_mode(hex_v[0]), .trig(trig_v[0]),
    .busy(busy_v[0]), .frame_done(fd_v[0]), .overrun(ov_v[0]), .uart_tx(tx_v[0]));
  uart_adc_report #(.CLK_FRE(1), .UART_RATE(200000), .SEND_FRE(2), .N_CH(2), .DATA_W(12)) u1 (
    .clk(clk), .rst(rst), .adc_data(adc1), .mode(mode_v[1]), .hex_mode(hex_v[1]), .trig(trig_v[1]),
    .busy(busy_v[1]), .frame_done(fd_v[1]), .overrun(ov_v[1]), .uart_tx(tx_v[1]));
  uart_adc_report #(.CLK_FRE(1), .UART_RATE(200000), .SEND_FRE(2), .N_CH(2), .DATA_W(16)) u2 (
    .clk(clk), .rst(rst), .adc_data(adc2), .mode(mode_v[2]), .hex_mode(hex_v[2]), .trig(trig_v[2]),
    .busy(busy_v[2]), .frame_done(fd_v[2]), .overrun(ov_v[2]), .uart_tx(tx_v[2]));

  // Event counters: frame_done pulses, send_en pulses, handshake violations.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) if (fd_v[k]) fd_cnt[k] <= fd_cnt[k] + 1;
    if (u0.send_en) se_cnt[0] <= se_cnt[0] + 1;
    if (u1.send_en) se_cnt[1] <= se_cnt[1] + 1;
    if (u2.send_en) se_cnt[2] <= se_cnt[2] + 1;
    if ((u0.send_en && u0.send_busy) || (u1.send_en && u1.send_busy) || (u2.send_en && u2.send_busy))
      hs_err <= hs_err + 1;
  end

  // UART receiver: find the start bit, sample each bit mid-period.
  task automatic mon(input int k);
    byte unsigned b;
    forever begin
      @(negedge clk);
      if (tx_v[k] == 1'b0) begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          b[i] = tx_v[k];
        end
        repeat (BIT_CLKS) @(negedge clk);
        if (tx_v[k] == 1'b1) rxq[k].push_back(b);
        else ferr = ferr + 1;
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'd13)      r = {r, "\\r"};
      else if (s[i] == 8'd10) r = {r, "\\n"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string to_str(input logic [127:0] v);
    string s = "";
    logic [7:0] b;
    for (int i = 15; i >= 0; i--) begin
      b = v[8*i +: 8];
      if (b != 8'd0) s = $sformatf("%s%c", s, b);
    end
    return {s, crlf};
  endfunction

  function automatic string drain(input int k);
    string s = "";
    while (rxq[k].size() > 0) s = $sformatf("%s%c", s, rxq[k].pop_front());
    return s;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, vis(act), vis(exp));
    end
  endtask

  task automatic set_in(input int k, input logic [15:0] c0, input logic [15:0] c1, input logic hx);
    case (k)
      0:       adc0 = {c1[7:0], c0[7:0]};
      1:       adc1 = {c1[11:0], c0[11:0]};
      default: adc2 = {c1, c0};
    endcase
    hex_v[k] = hx;
  endtask

  task automatic pulse_trig(input int k);
    trig_v[k] = 1'b1;
    @(negedge clk);
    trig_v[k] = 1'b0;
  endtask

  task automatic wait_fd(input int k, input int fd_b, output int timed_out);
    timed_out = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (fd_cnt[k] != fd_b) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic wait_busy(input int k, output int at, output int timed_out);
    timed_out = 1;
    at = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (busy_v[k] == 1'b1) begin
        timed_out = 0;
        at = cyc;
        break;
      end
    end
  endtask

  // One triggered frame: drive, push expectation, wait, compare.
  task automatic run_frame(input int k, input logic [15:0] c0, input logic [15:0] c1,
                           input logic hx, input string exp, input string tag);
    int fd_b, se_b, to;
    string e;
    @(negedge clk);
    set_in(k, c0, c1, hx);
    fd_b = fd_cnt[k];
    se_b = se_cnt[k];
    sb_q.push_back(exp);
    pulse_trig(k);
    wait_fd(k, fd_b, to);
    repeat (3) @(negedge clk);
    e = sb_q.pop_front();
    chk_int({tag, "_timeout"}, to, 0);
    chk_str({tag, "_frame"}, drain(k), e);
    chk_int({tag, "_frame_done_cnt"}, fd_cnt[k] - fd_b, 1);
    chk_int({tag, "_send_en_cnt"}, se_cnt[k] - se_b, e.len());
    chk_int({tag, "_busy_after"}, int'(busy_v[k]), 0);
  endtask

  initial begin
    int to, t1, t2, fd_b, se_b;
    string e;
    crlf = "\015\012";
    for (int k = 0; k < 3; k++) begin
      fd_cnt[k] = 0;
      se_cnt[k] = 0;
    end
    tbl[0] = '{k: 2'd0, c0: 16'h00FF, c1: 16'h0005, hx: 1'b0, txt: "AD:255,005"};
    tbl[1] = '{k: 2'd0, c0: 16'h0000, c1: 16'h0000, hx: 1'b0, txt: "AD:000,000"};
    tbl[2] = '{k: 2'd0, c0: 16'h003A, c1: 16'h00FF, hx: 1'b1, txt: "AD:3A,FF"};
    tbl[3] = '{k: 2'd0, c0: 16'd100,  c1: 16'd9,    hx: 1'b0, txt: "AD:100,009"};
    tbl[4] = '{k: 2'd1, c0: 16'h0ABC, c1: 16'h000F, hx: 1'b1, txt: "AD:ABC,00F"};
    tbl[5] = '{k: 2'd1, c0: 16'h0FFF, c1: 16'd123,  hx: 1'b0, txt: "AD:4095,0123"};
    tbl[6] = '{k: 2'd2, c0: 16'hFFFF, c1: 16'h0000, hx: 1'b0, txt: "AD:65535,00000"};
    tbl[7] = '{k: 2'd2, c0: 16'h1234, c1: 16'hBEEF, hx: 1'b1, txt: "AD:1234,BEEF"};
    tbl[8] = '{k: 2'd2, c0: 16'd10000, c1: 16'd99,  hx: 1'b0, txt: "AD:10000,00099"};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_int("reset_busy", int'(busy_v), 0);
    chk_int("reset_frame_done", int'(fd_v), 0);
    chk_int("reset_overrun", int'(ov_v), 0);

    // Table-driven triggered frames
    for (int i = 0; i < 9; i++)
      run_frame(int'(tbl[i].k), tbl[i].c0, tbl[i].c1, tbl[i].hx, to_str(tbl[i].txt),
                $sformatf("vec%0d", i));
    chk_int("no_overrun_after_table", int'(ov_v), 0);

    // Periodic mode: frame starts exactly one period apart, no overrun
    @(negedge clk);
    set_in(0, 16'h0080, 16'h0007, 1'b0);
    sb_q.push_back({"AD:128,007", crlf});
    sb_q.push_back({"AD:128,007", crlf});
    mode_v[0] = 1'b0;
    wait_busy(0, t1, to);
    chk_int("periodic_start1_timeout", to, 0);
    wait_fd(0, fd_cnt[0], to);
    wait_busy(0, t2, to);
    chk_int("periodic_start2_timeout", to, 0);
    wait_fd(0, fd_cnt[0], to);
    mode_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk_int("periodic_spacing", t2 - t1, 1000);
    e = sb_q.pop_front();
    e = {e, sb_q.pop_front()};
    chk_str("periodic_frames", drain(0), e);
    chk_int("periodic_overrun", int'(ov_v[0]), 0);

    // Trigger and data change mid-frame: overrun, single frame of the snapshot
    @(negedge clk);
    set_in(0, 16'h00FF, 16'h0005, 1'b0);
    fd_b = fd_cnt[0];
    sb_q.push_back({"AD:255,005", crlf});
    pulse_trig(0);
    repeat (100) @(negedge clk);
    set_in(0, 16'h0022, 16'h0011, 1'b1);
    pulse_trig(0);
    wait_fd(0, fd_b, to);
    chk_int("overrun_frame_timeout", to, 0);
    repeat (1200) @(negedge clk);
    chk_str("overrun_frame", drain(0), sb_q.pop_front());
    chk_int("overrun_single_frame", fd_cnt[0] - fd_b, 1);
    chk_int("overrun_sticky", int'(ov_v[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_int("overrun_cleared_by_rst", int'(ov_v[0]), 0);

    // Reset during byte 5: frame abandoned, next trigger gives a full frame
    set_in(0, 16'h00FF, 16'h0005, 1'b0);
    fd_b = fd_cnt[0];
    se_b = se_cnt[0];
    pulse_trig(0);
    to = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (se_cnt[0] - se_b >= 5) begin
        to = 0;
        break;
      end
    end
    chk_int("rst_mid_reach_byte5", to, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_int("rst_mid_busy_async", int'(busy_v[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk_int("rst_mid_no_frame_done", fd_cnt[0] - fd_b, 0);
    void'(drain(0));
    run_frame(0, 16'h00FF, 16'h0005, 1'b0, {"AD:255,005", crlf}, "after_rst");

    chk_int("handshake_violations", hs_err, 0);
    chk_int("uart_framing_errors", ferr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
